updown_mod_counter: RTL and testbench

//   Parametrised synchronous up/down modulo counter built from a generate chain of

---
 rtl/updown_mod_counter_pkg.sv | 21 ++
 rtl/updown_mod_counter_if.sv | 33 +++
 rtl/updown_mod_counter_toggle.sv | 27 ++
 rtl/updown_mod_counter.sv | 92 +++++++++
 tb/tb_updown_mod_counter.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/updown_mod_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnt_pkg
// Purpose  : Shared direction type and load-clamp helper for the modulo counter.
// Revision : 1.0  initial release
// ============================================================================
package cnt_pkg;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  // Wide arithmetic so MODULUS == 2**WIDTH is representable for any WIDTH.
  function automatic logic [63:0] clamp_load(input logic [63:0] value,
                                             input logic [63:0] modulus);
    return (value >= modulus) ? (modulus - 64'd1) : value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/updown_mod_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : updown_mod_counter_if
// Purpose  : Control and status bundle of the up/down modulo counter.
// Revision : 1.0  initial release
// ============================================================================
interface updown_mod_counter_if
  import cnt_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  logic             enable;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  cnt_dir_e         up_dn;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (
    output enable, clear, load, load_value, up_dn,
    input  q, tc, wrap
  );

  modport slave (
    input  enable, clear, load, load_value, up_dn,
    output q, tc, wrap
  );

endinterface
`default_nettype wire

// File: rtl/updown_mod_counter_toggle.sv
`default_nettype none
// ============================================================================
// Module   : toggle_cell
// Purpose  : Single T flip-flop, async active-low reset to 0.
// Revision : 1.0  initial release
// ============================================================================
module toggle_cell (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_t,
  output logic      o_q
);

  logic r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= 1'b0;
    end else begin
      r_q <= r_q ^ i_t;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : updown_mod_counter
// Purpose  : Up/down modulo counter on a toggle-cell chain with clear, load,
//            wrap/saturate mode, terminal count and wrap pulse.
// Revision : 1.0  initial release
// ============================================================================
module updown_mod_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter bit SATURATE = 1'b0
) (
  input wire logic               clk,
  input wire logic               reset,
  updown_mod_counter_if.slave    bus
);

  localparam logic [WIDTH-1:0] c_q_max = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] c_one   = WIDTH'(1);

  if ((MODULUS < 2) || (64'(MODULUS) > (64'd1 << WIDTH))) begin : g_bad_modulus
    $error("updown_mod_counter: MODULUS must be in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_next_q;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_up;
  logic             w_at_limit;
  logic             w_use_chain;
  logic             w_wrap_next;
  logic             r_wrap;

  assign w_up           = (bus.up_dn == CNT_UP);
  assign w_at_limit     = w_up ? (w_q == c_q_max) : (w_q == '0);
  assign w_load_clamped = WIDTH'(clamp_load(64'(bus.load_value), 64'(MODULUS)));

  always_comb begin
    w_next_q    = w_q;
    w_wrap_next = 1'b0;
    if (bus.clear) begin
      w_next_q = '0;
    end else if (bus.load) begin
      w_next_q = w_load_clamped;
    end else if (bus.enable) begin
      if (!w_at_limit) begin
        w_next_q = w_up ? (w_q + c_one) : (w_q - c_one);
      end else if (!SATURATE) begin
        w_next_q    = w_up ? '0 : c_q_max;
        w_wrap_next = 1'b1;
      end
    end
  end

  // Plain stepping rides the ripple-toggle chain; every other case forces
  // the cells straight to the target value.
  assign w_use_chain = bus.enable & ~bus.clear & ~bus.load & ~w_at_limit;

  assign w_carry[0] = 1'b1;
  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
    assign w_carry[gi] = w_carry[gi-1] & (w_up ? w_q[gi-1] : ~w_q[gi-1]);
  end

  assign w_t = w_use_chain ? w_carry : (w_q ^ w_next_q);

  for (genvar gb = 0; gb < WIDTH; gb++) begin : g_bit
    toggle_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .i_t   (w_t[gb]),
      .o_q   (w_q[gb])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_next;
    end
  end

  assign bus.q    = w_q;
  assign bus.tc   = w_at_limit;
  assign bus.wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_mod_counter
// Purpose  : Directed self-checking bench for the up/down modulo counter.
// Revision : 1.0  initial release
// ============================================================================
module tb_updown_mod_counter;
  import cnt_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  updown_mod_counter_if #(.WIDTH(4)) if_a ();
  updown_mod_counter_if #(.WIDTH(4)) if_s ();
  updown_mod_counter_if #(.WIDTH(8)) if_b ();

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_a (
    .clk (clk), .reset (reset), .bus (if_a)
  );
  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_s (
    .clk (clk), .reset (reset), .bus (if_s)
  );
  updown_mod_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0)) u_b (
    .clk (clk), .reset (reset), .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wraps;
    int exp;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    if_a.enable = 0; if_a.clear = 0; if_a.load = 0; if_a.load_value = '0; if_a.up_dn = CNT_UP;
    if_s.enable = 0; if_s.clear = 0; if_s.load = 0; if_s.load_value = '0; if_s.up_dn = CNT_UP;
    if_b.enable = 0; if_b.clear = 0; if_b.load = 0; if_b.load_value = '0; if_b.up_dn = CNT_UP;
    step(); step();
    check("rst_q_a", 32'(if_a.q), 0);
    check("rst_wrap_a", 32'(if_a.wrap), 0);
    check("rst_q_b", 32'(if_b.q), 0);
    check("rst_tc_a", 32'(if_a.tc), 0);
    reset = 1'b1;

    // 1: asynchronous reset mid-count
    if_a.enable = 1;
    for (int k = 0; k < 5; k++) step();
    check("t1_q5", 32'(if_a.q), 5);
    #3 reset = 1'b0;
    #1;
    check("t1_async_q", 32'(if_a.q), 0);
    check("t1_async_wrap", 32'(if_a.wrap), 0);
    step();
    check("t1_held_q", 32'(if_a.q), 0);
    reset = 1'b1;

    // 2: up count through the modulus
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = k % 10;
      check("t2_q", 32'(if_a.q), 32'(exp));
      check("t2_tc", 32'(if_a.tc), (exp == 9) ? 1 : 0);
      check("t2_wrap", 32'(if_a.wrap), (k == 10) ? 1 : 0);
    end
    if_a.enable = 0;

    // 3: down from zero, wrap vs saturate
    if_a.clear = 1;
    step();
    if_a.clear = 0;
    check("t3_clr", 32'(if_a.q), 0);
    if_a.up_dn = CNT_DOWN;
    if_s.up_dn = CNT_DOWN;
    #1;
    check("t3_tc_down0", 32'(if_a.tc), 1);
    if_a.enable = 1;
    if_s.enable = 1;
    step();
    check("t3_wrap_q", 32'(if_a.q), 9);
    check("t3_wrap_pulse", 32'(if_a.wrap), 1);
    check("t3_sat_q", 32'(if_s.q), 0);
    check("t3_sat_tc", 32'(if_s.tc), 1);
    check("t3_sat_wrap", 32'(if_s.wrap), 0);
    if_a.enable = 0;
    step();
    check("t3_hold_q", 32'(if_a.q), 9);
    check("t3_wrap_end", 32'(if_a.wrap), 0);
    if_s.enable = 0; if_s.load = 1; if_s.load_value = 4'd9;
    step();
    if_s.load = 0; if_s.enable = 1; if_s.up_dn = CNT_UP;
    step();
    check("t3_sat_top_q", 32'(if_s.q), 9);
    check("t3_sat_top_tc", 32'(if_s.tc), 1);
    check("t3_sat_top_wrap", 32'(if_s.wrap), 0);
    if_s.enable = 0;

    // 4: load, clamp, clear priority, load without enable
    if_a.up_dn = CNT_UP;
    if_a.enable = 1; if_a.load = 1; if_a.load_value = 4'd7;
    step();
    check("t4_load7", 32'(if_a.q), 7);
    if_a.load_value = 4'd12;
    step();
    check("t4_clamp", 32'(if_a.q), 9);
    check("t4_clamp_wrap", 32'(if_a.wrap), 0);
    if_a.clear = 1; if_a.load_value = 4'd7;
    step();
    check("t4_clr_pri", 32'(if_a.q), 0);
    if_a.clear = 0; if_a.enable = 0; if_a.load_value = 4'd3;
    step();
    check("t4_load_noen", 32'(if_a.q), 3);
    if_a.load = 0;

    // 5: hold then up, up, down
    for (int k = 0; k < 5; k++) begin
      step();
      check("t5_hold", 32'(if_a.q), 3);
    end
    if_a.enable = 1;
    step();
    check("t5_up1", 32'(if_a.q), 4);
    step();
    check("t5_up2", 32'(if_a.q), 5);
    if_a.up_dn = CNT_DOWN;
    step();
    check("t5_down", 32'(if_a.q), 4);
    if_a.enable = 0;

    // 6: power-of-two free-run
    wraps = 0;
    if_b.enable = 1;
    for (int k = 1; k <= 256; k++) begin
      step();
      exp = k % 256;
      if (if_b.wrap === 1'b1) wraps++;
      check("t6_q", 32'(if_b.q), 32'(exp));
      check("t6_tc", 32'(if_b.tc), (exp == 255) ? 1 : 0);
    end
    if_b.enable = 0;
    step();
    check("t6_final_q", 32'(if_b.q), 0);
    if (if_b.wrap === 1'b1) wraps++;
    check("t6_wrap_count", 32'(wraps), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
